// File: rtl/ctrl_pkg.sv
// Opcodes, sequencer states, instruction classes and strobe bundle for the hardwired control unit.
package ctrl_pkg;
    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned ALU_W    = 5;

    localparam int unsigned OP_LD   = 0,  OP_LDI  = 1,  OP_ST   = 2,  OP_ADD  = 3;
    localparam int unsigned OP_SUB  = 4,  OP_AND  = 5,  OP_OR   = 6,  OP_SHR  = 7;
    localparam int unsigned OP_SHL  = 8,  OP_ROR  = 9,  OP_ROL  = 10, OP_ADDI = 11;
    localparam int unsigned OP_ANDI = 12, OP_ORI  = 13, OP_MUL  = 14, OP_DIV  = 15;
    localparam int unsigned OP_BR   = 18, OP_JR   = 19, OP_IN   = 21, OP_OUT  = 22;
    localparam int unsigned OP_MFHI = 23, OP_MFLO = 24, OP_NOP  = 25, OP_HALT = 26;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(OP_ADD);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(OP_AND);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(OP_OR);

    typedef enum logic [3:0] {
        S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_RALU, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
        CL_BR, CL_JR, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_HALT
    } iclass_t;

    typedef struct packed {
        logic con_in, out_in, in_out, c_out, ba_out, r_out, r_in, grc, grb, gra;
        logic lo_out, lo_in, hi_out, hi_in, zhigh_out, zlow_out, z_in, y_in, ir_in;
        logic write, read, mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out;
    } strobes_t;

    // Immediate ALU forms reuse the register-form ALU codes.
    function automatic logic [ALU_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OPCODE_W'(OP_ANDI): return ALU_AND;
            OPCODE_W'(OP_ORI):  return ALU_OR;
            default:            return ALU_ADD;
        endcase
    endfunction
endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction class and final execute state.
// Opcodes 14/15 map to the mul/div class only when CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = OPCODE_W
) (
    input  logic [OPW-1:0] i_opcode,
    output iclass_t        o_class,
    output state_t         o_last
);
    always_comb begin
        o_class = CL_NOP;
        case (i_opcode) inside
            OPW'(OP_LD):                   o_class = CL_LD;
            OPW'(OP_LDI):                  o_class = CL_LDI;
            OPW'(OP_ST):                   o_class = CL_ST;
            [OPW'(OP_ADD):OPW'(OP_ROL)]:   o_class = CL_RALU;
            [OPW'(OP_ADDI):OPW'(OP_ORI)]:  o_class = CL_IMM;
`ifdef CTRL_MULDIV_EN
            OPW'(OP_MUL), OPW'(OP_DIV):    o_class = CL_MULDIV;
`endif
            OPW'(OP_BR):                   o_class = CL_BR;
            OPW'(OP_JR):                   o_class = CL_JR;
            OPW'(OP_IN):                   o_class = CL_IN;
            OPW'(OP_OUT):                  o_class = CL_OUT;
            OPW'(OP_MFHI):                 o_class = CL_MFHI;
            OPW'(OP_MFLO):                 o_class = CL_MFLO;
            OPW'(OP_NOP):                  o_class = CL_NOP;
            OPW'(OP_HALT):                 o_class = CL_HALT;
            default:                       o_class = CL_NOP;
        endcase
    end

    always_comb begin
        o_last = S_T3;
        case (o_class)
            CL_RALU, CL_IMM, CL_LDI: o_last = S_T5;
            CL_MULDIV, CL_BR:        o_last = S_T6;
            CL_LD, CL_ST:            o_last = S_T7;
            default:                 o_last = S_T3;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, opcode-dependent execute T3-T7, halt on request.
// CTRL_MULDIV_EN enables the mul/div execute sequence and the HI/LO/Zhigh strobes.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW  = OPCODE_W,
    parameter int unsigned ALUW = ALU_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     ir,
    input  logic            con_ff,
    input  logic            stop,
    output logic            PCout, PCin, IncPC,
    output logic            MARin, MDRin, MDRout, Read, Write,
    output logic            IRin, Yin, Zin, Zlowout, Zhighout,
    output logic            HIin, HIout, LOin, LOout,
    output logic            Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic            INout, OUTin, CONin,
    output logic [ALUW-1:0] alu_op,
    output logic            run
);
    state_t          r_state, w_next, w_last;
    iclass_t         w_class;
    strobes_t        w_strb;
    logic [ALUW-1:0] w_alu_op;
    logic [OPW-1:0]  w_opcode;
    logic            w_unused_ir;

    assign w_opcode    = ir[31 -: OPW];
    assign w_unused_ir = ^ir[31-OPW:0];

    ctrl_decode #(.OPW(OPW)) u_decode (
        .i_opcode (w_opcode),
        .o_class  (w_class),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_RST;
        else          r_state <= w_next;
    end

    // stop only matters on the edge leaving the final execute state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0:  w_next = S_T1;
            S_T1:  w_next = S_T2;
            S_T2:  w_next = S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (w_class == CL_HALT)    w_next = S_HALT;
                else if (r_state == w_last) w_next = stop ? S_HALT : S_T0;
                else                       w_next = state_t'(4'(r_state) + 4'd1);
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        w_strb   = '0;
        w_alu_op = '0;
        case (r_state)
            S_T0: begin w_strb.pc_out = 1'b1; w_strb.mar_in = 1'b1; w_strb.inc_pc = 1'b1; w_strb.z_in = 1'b1; end
            S_T1: begin w_strb.zlow_out = 1'b1; w_strb.pc_in = 1'b1; w_strb.read = 1'b1; w_strb.mdr_in = 1'b1; end
            S_T2: begin w_strb.mdr_out = 1'b1; w_strb.ir_in = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (w_class)
                    CL_RALU, CL_IMM, CL_LDI: begin
                        case (r_state)
                            S_T3: begin
                                w_strb.grb = 1'b1; w_strb.y_in = 1'b1;
                                if (w_class == CL_LDI) w_strb.ba_out = 1'b1;
                                else                   w_strb.r_out  = 1'b1;
                            end
                            S_T4: begin
                                w_strb.z_in = 1'b1;
                                if (w_class == CL_RALU) begin
                                    w_strb.grc = 1'b1; w_strb.r_out = 1'b1; w_alu_op = ALUW'(w_opcode);
                                end else begin
                                    w_strb.c_out = 1'b1;
                                    w_alu_op = (w_class == CL_IMM) ? ALUW'(imm_alu_op(OPCODE_W'(w_opcode)))
                                                                   : ALUW'(ALU_ADD);
                                end
                            end
                            S_T5: begin w_strb.zlow_out = 1'b1; w_strb.gra = 1'b1; w_strb.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_LD, CL_ST: begin
                        case (r_state)
                            S_T3: begin w_strb.grb = 1'b1; w_strb.ba_out = 1'b1; w_strb.y_in = 1'b1; end
                            S_T4: begin w_strb.c_out = 1'b1; w_strb.z_in = 1'b1; w_alu_op = ALUW'(ALU_ADD); end
                            S_T5: begin w_strb.zlow_out = 1'b1; w_strb.mar_in = 1'b1; end
                            S_T6: begin
                                w_strb.mdr_in = 1'b1;
                                if (w_class == CL_LD) w_strb.read = 1'b1;
                                else begin w_strb.gra = 1'b1; w_strb.r_out = 1'b1; end
                            end
                            S_T7: begin
                                if (w_class == CL_LD) begin
                                    w_strb.mdr_out = 1'b1; w_strb.gra = 1'b1; w_strb.r_in = 1'b1;
                                end else w_strb.write = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    CL_MULDIV: begin
                        case (r_state)
                            S_T3: begin w_strb.gra = 1'b1; w_strb.r_out = 1'b1; w_strb.y_in = 1'b1; end
                            S_T4: begin
                                w_strb.grb = 1'b1; w_strb.r_out = 1'b1; w_strb.z_in = 1'b1; w_alu_op = ALUW'(w_opcode);
                            end
                            S_T5: begin w_strb.zlow_out = 1'b1; w_strb.lo_in = 1'b1; end
                            S_T6: begin w_strb.zhigh_out = 1'b1; w_strb.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_BR: begin
                        case (r_state)
                            S_T3: begin w_strb.gra = 1'b1; w_strb.r_out = 1'b1; w_strb.con_in = 1'b1; end
                            S_T4: begin w_strb.pc_out = 1'b1; w_strb.y_in = 1'b1; end
                            S_T5: begin w_strb.c_out = 1'b1; w_strb.z_in = 1'b1; w_alu_op = ALUW'(ALU_ADD); end
                            S_T6: begin w_strb.zlow_out = 1'b1; w_strb.pc_in = con_ff; end
                            default: ;
                        endcase
                    end
                    CL_JR:   begin w_strb.gra = 1'b1; w_strb.r_out = 1'b1; w_strb.pc_in = 1'b1; end
                    CL_IN:   begin w_strb.in_out = 1'b1; w_strb.gra = 1'b1; w_strb.r_in = 1'b1; end
                    CL_OUT:  begin w_strb.gra = 1'b1; w_strb.r_out = 1'b1; w_strb.out_in = 1'b1; end
                    CL_MFHI: begin w_strb.hi_out = 1'b1; w_strb.gra = 1'b1; w_strb.r_in = 1'b1; end
                    CL_MFLO: begin w_strb.lo_out = 1'b1; w_strb.gra = 1'b1; w_strb.r_in = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
`ifndef CTRL_MULDIV_EN
        w_strb.hi_in     = 1'b0;
        w_strb.lo_in     = 1'b0;
        w_strb.zhigh_out = 1'b0;
`endif
    end

    assign {CONin, OUTin, INout, Cout, BAout, Rout, Rin, Grc, Grb, Gra} =
           {w_strb.con_in, w_strb.out_in, w_strb.in_out, w_strb.c_out, w_strb.ba_out,
            w_strb.r_out, w_strb.r_in, w_strb.grc, w_strb.grb, w_strb.gra};
    assign {LOout, LOin, HIout, HIin, Zhighout, Zlowout, Zin, Yin, IRin} =
           {w_strb.lo_out, w_strb.lo_in, w_strb.hi_out, w_strb.hi_in, w_strb.zhigh_out,
            w_strb.zlow_out, w_strb.z_in, w_strb.y_in, w_strb.ir_in};
    assign {Write, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout} =
           {w_strb.write, w_strb.read, w_strb.mdr_out, w_strb.mdr_in, w_strb.mar_in,
            w_strb.inc_pc, w_strb.pc_in, w_strb.pc_out};
    assign alu_op = w_alu_op;
    assign run    = (r_state != S_RST) && (r_state != S_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-timeline model checked every cycle, plus directed literal checks.
module tb_control_sequencer;
    logic        clk, reset_n, con_ff, stop, run;
    logic [31:0] ir;
    logic [4:0]  alu_op;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout;
    logic HIin, HIout, LOin, LOout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, INout, OUTin, CONin;
    logic [26:0] w_dut;

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .INout(INout),
        .OUTin(OUTin), .CONin(CONin), .alu_op(alu_op), .run(run)
    );

    assign w_dut = {CONin, OUTin, INout, Cout, BAout, Rout, Rin, Grc, Grb, Gra, LOout, LOin, HIout,
                    HIin, Zhighout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout, MDRin, MARin,
                    IncPC, PCin, PCout};

    localparam logic [26:0] M_PCOUT = 27'd1 << 0,  M_PCIN  = 27'd1 << 1,  M_INCPC = 27'd1 << 2;
    localparam logic [26:0] M_MARIN = 27'd1 << 3,  M_MDRIN = 27'd1 << 4,  M_MDROUT = 27'd1 << 5;
    localparam logic [26:0] M_READ  = 27'd1 << 6,  M_WRITE = 27'd1 << 7,  M_IRIN  = 27'd1 << 8;
    localparam logic [26:0] M_YIN   = 27'd1 << 9,  M_ZIN   = 27'd1 << 10, M_ZLOW  = 27'd1 << 11;
    localparam logic [26:0] M_ZHIGH = 27'd1 << 12, M_HIIN  = 27'd1 << 13, M_HIOUT = 27'd1 << 14;
    localparam logic [26:0] M_LOIN  = 27'd1 << 15, M_LOOUT = 27'd1 << 16, M_GRA   = 27'd1 << 17;
    localparam logic [26:0] M_GRB   = 27'd1 << 18, M_GRC   = 27'd1 << 19, M_RIN   = 27'd1 << 20;
    localparam logic [26:0] M_ROUT  = 27'd1 << 21, M_BAOUT = 27'd1 << 22, M_COUT  = 27'd1 << 23;
    localparam logic [26:0] M_INOUT = 27'd1 << 24, M_OUTIN = 27'd1 << 25, M_CONIN = 27'd1 << 26;

    localparam int MD_RST = 0, MD_RUN = 1, MD_HALT = 2;

    int n_assert = 0, n_fail = 0;
    int m_mode = MD_RST, m_pos = 0;
    logic [4:0] m_op = 5'd25;
    bit rand_en = 0;
    int o_lat, o_marin, o_alu;
    bit o_pcin;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clocks per instruction, fetch included.
    function automatic int len_of(input logic [4:0] op);
        if (op == 5'd0 || op == 5'd2) return 8;
        if (op == 5'd1 || (op >= 5'd3 && op <= 5'd13)) return 6;
        if (op == 5'd18) return 7;
`ifdef CTRL_MULDIV_EN
        if (op == 5'd14 || op == 5'd15) return 7;
`endif
        return 4;
    endfunction

    function automatic logic [26:0] exp_strb(input logic [4:0] op, input int pos, input bit cf);
        logic [26:0] s [0:7];
        for (int i = 0; i < 8; i++) s[i] = '0;
        s[0] = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
        s[1] = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
        s[2] = M_MDROUT | M_IRIN;
        if (op >= 5'd3 && op <= 5'd10) begin
            s[3] = M_GRB | M_ROUT | M_YIN; s[4] = M_GRC | M_ROUT | M_ZIN; s[5] = M_ZLOW | M_GRA | M_RIN;
        end else if ((op >= 5'd11 && op <= 5'd13) || op == 5'd1) begin
            s[3] = M_GRB | ((op == 5'd1) ? M_BAOUT : M_ROUT) | M_YIN;
            s[4] = M_COUT | M_ZIN; s[5] = M_ZLOW | M_GRA | M_RIN;
        end else if (op == 5'd0 || op == 5'd2) begin
            s[3] = M_GRB | M_BAOUT | M_YIN; s[4] = M_COUT | M_ZIN; s[5] = M_ZLOW | M_MARIN;
            s[6] = (op == 5'd0) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            s[7] = (op == 5'd0) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
`ifdef CTRL_MULDIV_EN
        end else if (op == 5'd14 || op == 5'd15) begin
            s[3] = M_GRA | M_ROUT | M_YIN; s[4] = M_GRB | M_ROUT | M_ZIN;
            s[5] = M_ZLOW | M_LOIN; s[6] = M_ZHIGH | M_HIIN;
`endif
        end else if (op == 5'd18) begin
            s[3] = M_GRA | M_ROUT | M_CONIN; s[4] = M_PCOUT | M_YIN; s[5] = M_COUT | M_ZIN;
            s[6] = M_ZLOW | (cf ? M_PCIN : 27'd0);
        end else if (op == 5'd19) s[3] = M_GRA | M_ROUT | M_PCIN;
        else if (op == 5'd21) s[3] = M_INOUT | M_GRA | M_RIN;
        else if (op == 5'd22) s[3] = M_GRA | M_ROUT | M_OUTIN;
        else if (op == 5'd23) s[3] = M_HIOUT | M_GRA | M_RIN;
        else if (op == 5'd24) s[3] = M_LOOUT | M_GRA | M_RIN;
        return s[pos];
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] op, input int pos);
        if (pos == 4 && op <= 5'd2) return 5'd3;
        if (pos == 4 && op >= 5'd3 && op <= 5'd10) return op;
        if (pos == 4 && op == 5'd11) return 5'd3;
        if (pos == 4 && op == 5'd12) return 5'd5;
        if (pos == 4 && op == 5'd13) return 5'd6;
`ifdef CTRL_MULDIV_EN
        if (pos == 4 && (op == 5'd14 || op == 5'd15)) return op;
`endif
        if (pos == 5 && op == 5'd18) return 5'd3;
        return 5'd0;
    endfunction

    // Advance the timeline by one edge using the inputs the DUT samples at that edge.
    task automatic model_step();
        if (!reset_n) m_mode = MD_RST;
        else if (m_mode == MD_RST) begin m_mode = MD_RUN; m_pos = 0; end
        else if (m_mode == MD_RUN) begin
            if (m_pos == len_of(m_op) - 1) begin
                if (m_op == 5'd26 || stop) m_mode = MD_HALT;
                else m_pos = 0;
            end else m_pos++;
        end
    endtask

    task automatic tick(input bit rst, input bit stp, input bit cf);
        @(posedge clk);
        model_step();
        #1;
        reset_n = rst; stop = stp; con_ff = cf;
        if (m_mode == MD_RUN && m_pos == 3) begin
            if (rand_en) m_op = 5'($urandom_range(0, 31));
            ir = {m_op, 27'($urandom)};
        end else if (m_mode != MD_RUN || m_pos < 3) ir = $urandom;
        @(negedge clk);
        if (m_mode == MD_RUN) begin
            check("strobes", 32'(w_dut), 32'(exp_strb(m_op, m_pos, con_ff)));
            check("alu_op", 32'(alu_op), 32'(exp_alu(m_op, m_pos)));
            check("run", 32'(run), 32'd1);
        end else begin
            check("strobes_idle", 32'(w_dut), 32'd0);
            check("alu_op_idle", 32'(alu_op), 32'd0);
            check("run_idle", 32'(run), 32'd0);
        end
    endtask

    // Runs one instruction from T0, observing DUT until the next T0 or a halt.
    task automatic run_op(input logic [4:0] op, input bit cf, input bit stp);
        o_lat = 0; o_marin = -1; o_alu = -1; o_pcin = 0;
        m_op = op;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, stp, cf);
            if (!run || (PCout && MARin)) begin o_lat = i; break; end
            if (MARin) o_marin = i;
            if (PCin && i >= 3) o_pcin = 1;
            if (Zin) o_alu = int'(alu_op);
        end
        if (o_lat == 0) check("instr_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = '0;
        tick(0, 0, 0); tick(0, 0, 0);
        check("reset_outputs", 32'(w_dut), 32'd0);
        check("reset_run", 32'(run), 32'd0);
        tick(1, 0, 0); tick(1, 0, 0);
        check("t0_strobes", 32'(w_dut), 32'h40D);

        run_op(5'd3, 0, 0);
        check("add_latency", o_lat, 6); check("add_alu", o_alu, 3);
        run_op(5'd0, 0, 0);
        check("ld_latency", o_lat, 8); check("ld_marin_t5", o_marin, 5);
        run_op(5'd18, 1, 0);
        check("br_taken_latency", o_lat, 7); check("br_taken_pcin", 32'(o_pcin), 32'd1);
        run_op(5'd18, 0, 0);
        check("br_nottaken_pcin", 32'(o_pcin), 32'd0);
        run_op(5'd22, 0, 0); check("out_latency", o_lat, 4);
        run_op(5'd21, 0, 0); check("in_latency", o_lat, 4);
`ifdef CTRL_MULDIV_EN
        run_op(5'd14, 0, 0); check("mul_latency", o_lat, 7);
`else
        run_op(5'd14, 0, 0); check("mul_as_nop_latency", o_lat, 4);
`endif
        run_op(5'd31, 0, 0); check("undef_latency", o_lat, 4);

        run_op(5'd3, 0, 1);
        check("stop_add_latency", o_lat, 6); check("stop_halted", 32'(run), 32'd0);
        tick(1, 0, 0); check("halt_held", 32'(run), 32'd0);
        tick(0, 0, 0); tick(1, 0, 0); tick(1, 0, 0);
        run_op(5'd26, 0, 0);
        check("halt_latency", o_lat, 4); check("halt_run", 32'(run), 32'd0);
        tick(0, 0, 0); tick(1, 0, 0); tick(1, 0, 0);

        m_op = 5'd0;
        for (int i = 0; i < 4; i++) tick(1, 0, 0);
        tick(0, 0, 0);
        check("ld_t5_strobes", 32'(w_dut), 32'h808);
        tick(1, 0, 0);
        check("mid_reset_outputs", 32'(w_dut), 32'd0);
        tick(1, 0, 0);
        check("mid_reset_t0", 32'(w_dut), 32'h40D);

        rand_en = 1;
        for (int c = 0; c < 3000; c++) begin
            bit r;
            r = (m_mode == MD_HALT) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) != 0);
            tick(r, $urandom_range(0, 24) == 0, 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
